// File: rtl/mcu_sched.sv
// -----------------------------------------------------------------------------
// mcu_sched -- block scheduler between the JPEG entropy decoder and the
// deQuant/IDCT stage.
//
// Each MCU is Y_PER_MCU luma blocks (ch 0), then one Cb block (ch 1), then
// one Cr block (ch 2). The scheduler accepts blocks from the decoder and
// tags each one with its channel. A one-entry output register presents the
// tagged block downstream.
//
// Parameters
//   Y_PER_MCU : luma blocks per MCU (1, 2 or 4)
//   CNT_W     : MCU counter width
//
// Ports
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   start     : one-cycle pulse that begins an image (sampled only in IDLE)
//   num_mcus  : MCUs in the image, captured on start
//   in_valid  : decoder has a block
//   in_ready  : scheduler accepts a block this cycle
//   out_valid : a block is presented downstream
//   out_ready : downstream accepts the block
//   ch_out    : channel of the presented block (0=Y, 1=Cb, 2=Cr)
//   blk_load  : external block register load strobe (in_valid & in_ready)
//   busy      : state is not IDLE
//   done      : one-cycle pulse after the last block is taken downstream
//   err       : (only with MCU_SCHED_ERR_EN) sticky protocol error
//
// Optional feature macro: MCU_SCHED_ERR_EN adds the err output and its logic.
// -----------------------------------------------------------------------------
module mcu_sched #(
  parameter int Y_PER_MCU = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_mcus,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       ch_out,
  output logic             blk_load,
  output logic             busy,
  output logic             done
`ifdef MCU_SCHED_ERR_EN
  ,output logic            err
`endif
);

  // Block index runs 0 .. Y_PER_MCU+1 within one MCU.
  localparam int IDX_W = $clog2(Y_PER_MCU + 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_blk_idx;
  logic [CNT_W-1:0] r_mcu_cnt;
  logic [CNT_W-1:0] r_last_mcu;
  logic             r_out_valid;
  logic [1:0]       r_ch;
  logic             r_done;

  logic             w_in_ready;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic [1:0]       w_cur_ch;
  logic             w_last_blk;
  logic             w_last_mcu;

  // The output register can take a new block when empty or when it empties
  // in this same cycle, so a continuous stream moves with no bubble.
  assign w_in_ready = (r_state == S_RUN) & (~r_out_valid | out_ready);
  assign w_in_xfer  = in_valid & w_in_ready;
  assign w_out_xfer = r_out_valid & out_ready;

  assign w_last_blk = (r_blk_idx == IDX_W'(Y_PER_MCU + 1));
  // Compare against num_mcus-1, so num_mcus = 2^CNT_W-1 still terminates
  // before the counter wraps.
  assign w_last_mcu = (r_mcu_cnt == r_last_mcu);

  always_comb begin
    w_cur_ch = 2'd2;
    if (r_blk_idx < IDX_W'(Y_PER_MCU))
      w_cur_ch = 2'd0;
    else if (r_blk_idx == IDX_W'(Y_PER_MCU))
      w_cur_ch = 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_blk_idx   <= '0;
      r_mcu_cnt   <= '0;
      r_last_mcu  <= '0;
      r_out_valid <= 1'b0;
      r_ch        <= 2'd0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (num_mcus == '0) begin
              // Empty image: report completion without leaving IDLE.
              r_done <= 1'b1;
            end else begin
              r_state    <= S_RUN;
              r_last_mcu <= num_mcus - CNT_W'(1);
              r_mcu_cnt  <= '0;
              r_blk_idx  <= '0;
            end
          end
        end
        S_RUN: begin
          if (w_in_xfer) begin
            if (w_last_blk) begin
              r_blk_idx <= '0;
              r_mcu_cnt <= r_mcu_cnt + CNT_W'(1);
              if (w_last_mcu)
                r_state <= S_FLUSH;
            end else begin
              r_blk_idx <= r_blk_idx + IDX_W'(1);
            end
          end
        end
        S_FLUSH: begin
          // The last block always sits in the output register here.
          if (w_out_xfer) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // One-entry output register; a load wins over an unload.
      if (w_in_xfer) begin
        r_out_valid <= 1'b1;
        r_ch        <= w_cur_ch;
      end else if (w_out_xfer) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign blk_load  = w_in_xfer;
  assign out_valid = r_out_valid;
  assign ch_out    = r_ch;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;

`ifdef MCU_SCHED_ERR_EN
  logic r_err;

  // A new start clears the flag; extra blocks outside RUN or a start while
  // busy set it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_err <= 1'b0;
    else if (start && (r_state == S_IDLE))
      r_err <= 1'b0;
    else if ((in_valid && (r_state != S_RUN)) || (start && (r_state != S_IDLE)))
      r_err <= 1'b1;
  end

  assign err = r_err;
`endif

endmodule

// File: doc/mcu_sched.md
MCU_SCHED -- requirements
Module: mcu_sched

Interface
REQ-001 SHALL have parameter Y_PER_MCU, default 4, meaning luma blocks per MCU; legal values 1, 2, 4.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the MCU counter width.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state is rising-edge.
REQ-004 SHALL have port rst_n, input, 1, meaning the reset: asynchronous, active-low.
REQ-005 SHALL have port start, input, 1, meaning a one-cycle pulse that begins an image; sampled only in IDLE.
REQ-006 SHALL have port num_mcus, input, CNT_W, meaning MCUs in the image; captured on start.
REQ-007 SHALL have port in_valid, input, 1, meaning the entropy decoder has a block.
REQ-008 SHALL have port in_ready, output, 1, meaning the scheduler accepts a block this cycle.
REQ-009 SHALL have port out_valid, output, 1, meaning a block is presented to deQuant/IDCT.
REQ-010 SHALL have port out_ready, input, 1, meaning downstream accepts the block.
REQ-011 SHALL have port ch_out, output, $clog2(`CH+1), meaning the channel of the presented block (0=Y, 1=Cb, 2=Cr).
REQ-012 SHALL have port blk_load, output, 1, meaning the external block register loads the input block (equals in_valid & in_ready).
REQ-013 SHALL have port busy, output, 1, meaning the state is not IDLE.
REQ-014 SHALL have port done, output, 1, meaning a one-cycle pulse after the last block of the image is accepted downstream.

Function
REQ-015 SHALL implement states IDLE, RUN and FLUSH.
REQ-016 SHALL move IDLE->RUN on start and capture num_mcus; a start with num_mcus=0 SHALL pulse done the next cycle and stay in IDLE.
REQ-017 SHALL hold a one-entry output register {out_valid, ch_out}; in_ready = (state==RUN) & (~out_valid | out_ready).
REQ-018 SHALL, on an input transfer, load out_valid=1 with ch_out = the current sequence channel in the same cycle; latency is 1 cycle from input transfer to out_valid.
REQ-019 SHALL clear out_valid on an output transfer with no simultaneous input transfer; a simultaneous input and output transfer SHALL reload the register with no bubble.
REQ-020 SHALL use the channel sequence per MCU: Y_PER_MCU blocks with ch 0, then one block with ch 1, then one block with ch 2; block index wraps to 0 after Cr and the MCU counter increments.
REQ-021 SHALL move RUN->FLUSH on acceptance of the Cr block of MCU num_mcus-1; in FLUSH in_ready=0.
REQ-022 SHALL move FLUSH->IDLE and pulse done when the final block transfers downstream; if that transfer happens in the same cycle as the last input transfer, the block is still presented for one cycle first.
REQ-023 SHALL hold out_valid and ch_out stable while out_valid=1 and out_ready=0.
REQ-024 SHALL ignore start outside IDLE.
REQ-025 SHALL count MCUs modulo 2^CNT_W internally; num_mcus = 2^CNT_W-1 SHALL complete normally.

Reset
REQ-026 SHALL, on rst_n low at any time (including mid-image), asynchronously force state IDLE, out_valid=0, ch_out=0, in_ready=0, blk_load=0, busy=0, done=0, and clear both counters.
REQ-027 SHALL leave an in-flight block undelivered after reset; no done pulse is generated for the aborted image.

Configuration
REQ-028 SHALL, when macro MCU_SCHED_ERR_EN is defined, add an output err (1 bit, sticky until reset or start) that sets when in_valid=1 in FLUSH or IDLE (excess block) or when start arrives while busy.
REQ-029 SHALL, without MCU_SCHED_ERR_EN, have no err port and no error logic; behaviour is otherwise identical.

Verification
REQ-030 SHALL verify: Y_PER_MCU=4, num_mcus=2, in_valid and out_ready held at 1 -> ch_out sequence 0,0,0,0,1,2,0,0,0,0,1,2, done pulses once, one cycle after the 12th out transfer.
REQ-031 SHALL verify: out_ready=0 for 5 cycles mid-stream -> in_ready=0 and out_valid/ch_out held constant, with no block lost or duplicated.
REQ-032 SHALL verify: start with num_mcus=0 -> done the next cycle, busy never asserts, and in_ready stays 0.
REQ-033 SHALL verify: rst_n asserted low after the 3rd block of MCU 0 -> all outputs reach reset values immediately; a new start with num_mcus=1 yields the sequence 0,0,0,0,1,2.
REQ-034 SHALL verify: Y_PER_MCU=1, num_mcus=3 with random in_valid/out_ready -> channel sequence 0,1,2 repeated 3 times and 9 transfers total.
REQ-035 SHALL verify, with MCU_SCHED_ERR_EN: an extra in_valid during FLUSH -> err=1 and held; the next start clears it.
